renode_gpio_bridge: RTL and testbench

Synthesizable, parametrised GPIO/interrupt bridge between the Renode co-simulation connection and the DUT. It replaces per-message blocking output updates with a queued command channel supporting level and timed-pulse modes. It also adds per-input edge qualification and an event queue reporting DUT signal changes back towards Renode. It sits between the connection-side message handler (command producer / event consumer) and DUT interrupt and GPIO wires.

---
 rtl/renode_pkg.sv | 37 +++
 rtl/renode_gpio_bridge_if.sv | 39 +++
 rtl/renode_sync_fifo.sv | 72 +++++++
 rtl/renode_gpio_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_renode_gpio_bridge.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/renode_pkg.sv
// renode_pkg: shared types for the Renode GPIO/interrupt bridge.
//   gpio_cmd_t        - queued output command (index, level, pulse flag, length)
//   gpio_evt_t        - queued input event (index, sampled level)
//   gpio_exec_state_e - command executor states
// Struct fields are sized for the largest supported configuration
// (1024 outputs/inputs, pulse field up to 32 bits); the bridge zero-extends
// narrower fields on the way in.
package renode_pkg;

  localparam int GPIO_NUM_W     = 11;  // $clog2(1024) + 1 range-detect bit
  localparam int GPIO_EVT_NUM_W = 10;  // $clog2(1024)
  localparam int GPIO_CYCLES_W  = 32;

  typedef enum logic [1:0] {
    GPIO_IDLE  = 2'd0,
    GPIO_EXEC  = 2'd1,
    GPIO_PULSE = 2'd2
  } gpio_exec_state_e;

  typedef struct packed {
    logic [GPIO_NUM_W-1:0]    number;
    logic                     value;
    logic                     pulse;
    logic [GPIO_CYCLES_W-1:0] cycles;
  } gpio_cmd_t;

  typedef struct packed {
    logic [GPIO_EVT_NUM_W-1:0] number;
    logic                      value;
  } gpio_evt_t;

  // A zero-length pulse still lasts one cycle.
  function automatic logic [GPIO_CYCLES_W-1:0] pulse_load(input logic [GPIO_CYCLES_W-1:0] c);
    return (c == '0) ? GPIO_CYCLES_W'(1) : c;
  endfunction

endpackage

// File: rtl/renode_gpio_bridge_if.sv
// renode_gpio_bridge_if: connection-side bus of the GPIO bridge.
//   cmd_*  : command channel (master -> bridge)
//   rsp_*  : one-cycle execution response (bridge -> master)
//   evt_*  : input-change event channel (bridge -> master)
// Handshake rule for cmd and evt: a transfer happens on a rising clk edge
// where valid and ready are both high; the producer holds valid and payload
// stable until that edge, and ready may depend combinationally on state only.
interface renode_gpio_bridge_if #(
  parameter int OutputsCount = 32,
  parameter int InputsCount  = 32,
  parameter int PulseWidth   = 16
);
  localparam int CNW = $clog2((OutputsCount > 2) ? OutputsCount : 2) + 1;
  localparam int EW  = $clog2((InputsCount > 2) ? InputsCount : 2);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CNW-1:0]        cmd_number;
  logic                  cmd_value;
  logic                  cmd_pulse;
  logic [PulseWidth-1:0] cmd_cycles;
  logic                  rsp_valid;
  logic                  rsp_error;
  logic                  evt_valid;
  logic                  evt_ready;
  logic [EW-1:0]         evt_number;
  logic                  evt_value;
  logic                  evt_coalesced;

  modport master (
    output cmd_valid, cmd_number, cmd_value, cmd_pulse, cmd_cycles, evt_ready,
    input  cmd_ready, rsp_valid, rsp_error, evt_valid, evt_number, evt_value, evt_coalesced
  );

  modport slave (
    input  cmd_valid, cmd_number, cmd_value, cmd_pulse, cmd_cycles, evt_ready,
    output cmd_ready, rsp_valid, rsp_error, evt_valid, evt_number, evt_value, evt_coalesced
  );
endinterface

// File: rtl/renode_sync_fifo.sv
// renode_sync_fifo: single-clock FIFO of element type T.
//   clk, reset : synchronous active-high reset empties the FIFO
//   push, din  : write when push && !full
//   pop, dout  : dout is the head; advance when pop && !empty
//   full, empty: derived from the registered occupancy count, so a pop does
//                not make room for a push in the same cycle and a freshly
//                written entry cannot be popped in its write cycle.
// Depth must be a power of two (pointers wrap naturally).
module renode_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  Depth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  T              mem_q [Depth];
  T              mem_d [Depth];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/renode_gpio_bridge.sv
// renode_gpio_bridge: GPIO/interrupt bridge between the Renode connection
// and DUT wires.
//   clk, reset      : single clock, synchronous active-high reset
//   bus (slave)     : cmd/rsp/evt channels towards the connection handler
//   renode_outputs  : levels driven by queued level/pulse commands
//   renode_inputs   : DUT signals (already synchronous to clk)
//   rise_enable,
//   fall_enable     : per-input edge qualification
//   dbg_state       : executor FSM state (gpio_exec_state_e encoding)
// Commands are queued and executed one at a time (IDLE -> EXEC [-> PULSE]).
// Qualified input edges set per-input pending bits; a lowest-index arbiter
// moves one pending input per cycle into the event queue.
module renode_gpio_bridge
  import renode_pkg::*;
#(
  parameter int OutputsCount   = 32,
  parameter int InputsCount    = 32,
  parameter int CmdFifoDepth   = 4,
  parameter int EventFifoDepth = 8,
  parameter int PulseWidth     = 16   // at most GPIO_CYCLES_W
) (
  input  logic                    clk,
  input  logic                    reset,
  renode_gpio_bridge_if.slave     bus,
  output logic [OutputsCount-1:0] renode_outputs,
  input  logic [InputsCount-1:0]  renode_inputs,
  input  logic [InputsCount-1:0]  rise_enable,
  input  logic [InputsCount-1:0]  fall_enable,
  output logic [1:0]              dbg_state
);
  localparam int EW = $clog2((InputsCount > 2) ? InputsCount : 2);

  localparam logic [1:0] ST_IDLE  = GPIO_IDLE;
  localparam logic [1:0] ST_EXEC  = GPIO_EXEC;
  localparam logic [1:0] ST_PULSE = GPIO_PULSE;

  // ---------------- command queue ----------------
  gpio_cmd_t             cmd_in, cmd_head;
  logic                  cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [PulseWidth-1:0] cmd_cycles_w;

  assign cmd_cycles_w  = bus.cmd_cycles;
  assign cmd_in        = '{number: GPIO_NUM_W'(bus.cmd_number),
                           value:  bus.cmd_value,
                           pulse:  bus.cmd_pulse,
                           cycles: GPIO_CYCLES_W'(cmd_cycles_w)};
  assign bus.cmd_ready = !cmd_full && !reset;
  assign cmd_push      = bus.cmd_valid && bus.cmd_ready;

  renode_sync_fifo #(.T(gpio_cmd_t), .Depth(CmdFifoDepth)) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_push),
    .din   (cmd_in),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  // ---------------- executor ----------------
  logic [1:0]               state_q, state_d;
  gpio_cmd_t                cur_q, cur_d;
  logic [GPIO_CYCLES_W-1:0] cnt_q, cnt_d;
  logic [OutputsCount-1:0]  out_q, out_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_error_q, rsp_error_d;
  logic                     in_range;

  assign in_range = (32'(cur_q.number) < 32'(OutputsCount));

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    cmd_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          cur_d   = cmd_head;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
        if (!in_range) begin
          rsp_error_d = 1'b1;
        end else begin
          for (int i = 0; i < OutputsCount; i++) begin
            if (cur_q.number == GPIO_NUM_W'(i)) out_d[i] = cur_q.value;
          end
          if (cur_q.pulse) begin
            cnt_d   = pulse_load(cur_q.cycles);
            state_d = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        if (cnt_q == GPIO_CYCLES_W'(1)) begin
          for (int i = 0; i < OutputsCount; i++) begin
            if (cur_q.number == GPIO_NUM_W'(i)) out_d[i] = !cur_q.value;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
          // Fetch the next command on the revert edge so its effect lands
          // on the very next edge instead of costing an extra IDLE cycle.
          if (!cmd_empty) begin
            cmd_pop = 1'b1;
            cur_d   = cmd_head;
            state_d = ST_EXEC;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign renode_outputs = out_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_error  = rsp_error_q;
  assign dbg_state      = state_q;

  // ---------------- input path ----------------
  logic [InputsCount-1:0] in_s_q, in_s_d, in_p_q, in_p_d;
  logic [InputsCount-1:0] pending_q, pending_d;
  logic [InputsCount-1:0] edges, clear_mask;
  logic                   primed_q, primed_d;
  logic                   coalesced_q, coalesced_d;
  logic [EW-1:0]          evt_idx;
  logic                   evt_push, evt_pop, evt_full, evt_empty;
  gpio_evt_t              evt_in, evt_head;

  function automatic logic [EW-1:0] lowest_idx(input logic [InputsCount-1:0] v);
    logic [EW-1:0] idx;
    idx = '0;
    for (int i = InputsCount - 1; i >= 0; i--) begin
      if (v[i]) idx = EW'(i);
    end
    return idx;
  endfunction

  assign evt_idx  = lowest_idx(pending_q);
  assign evt_push = (pending_q != '0) && !evt_full;
  assign evt_in   = '{number: GPIO_EVT_NUM_W'(evt_idx), value: in_s_q[evt_idx]};

  always_comb begin
    // The first cycle out of reset loads both stages with the same sample,
    // so whatever level the DUT holds is not mistaken for an edge.
    primed_d = 1'b1;
    in_s_d   = renode_inputs;
    in_p_d   = primed_q ? in_s_q : renode_inputs;
    edges    = primed_q ? (((in_s_q & ~in_p_q) & rise_enable) |
                           ((~in_s_q & in_p_q) & fall_enable)) : '0;
    for (int i = 0; i < InputsCount; i++) begin
      clear_mask[i] = evt_push && (evt_idx == EW'(i));
    end
    // A new edge wins over the arbiter clearing the same bit.
    pending_d   = (pending_q & ~clear_mask) | edges;
    coalesced_d = coalesced_q | (|(edges & pending_q));
  end

  renode_sync_fifo #(.T(gpio_evt_t), .Depth(EventFifoDepth)) u_evt_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (evt_push),
    .din   (evt_in),
    .pop   (evt_pop),
    .dout  (evt_head),
    .full  (evt_full),
    .empty (evt_empty)
  );

  assign evt_pop           = bus.evt_ready && !evt_empty;
  assign bus.evt_valid     = !evt_empty;
  assign bus.evt_number    = evt_head.number[EW-1:0];
  assign bus.evt_value     = evt_head.value;
  assign bus.evt_coalesced = coalesced_q;

  if (EW < GPIO_EVT_NUM_W) begin : g_evt_hi
    logic unused_evt_hi;
    assign unused_evt_hi = ^evt_head.number[GPIO_EVT_NUM_W-1:EW];
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      in_s_q      <= '0;
      in_p_q      <= '0;
      pending_q   <= '0;
      primed_q    <= 1'b0;
      coalesced_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      in_s_q      <= in_s_d;
      in_p_q      <= in_p_d;
      pending_q   <= pending_d;
      primed_q    <= primed_d;
      coalesced_q <= coalesced_d;
    end
  end
endmodule

// File: tb/tb_renode_gpio_bridge.sv
// Directed bench for renode_gpio_bridge (32 outputs, 32 inputs, cmd depth 4,
// event depth 8). All sampling happens on the falling edge; inputs are driven
// right after sampling so they are stable at the next rising edge.
module tb_renode_gpio_bridge;
  logic        clk;
  logic        reset;
  logic [31:0] renode_outputs;
  logic [31:0] renode_inputs;
  logic [31:0] rise_enable;
  logic [31:0] fall_enable;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];  // expected events {number, value}

  renode_gpio_bridge_if #(.OutputsCount(32), .InputsCount(32), .PulseWidth(16)) bus_if ();

  renode_gpio_bridge #(
    .OutputsCount(32), .InputsCount(32), .CmdFifoDepth(4), .EventFifoDepth(8), .PulseWidth(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus_if),
    .renode_outputs (renode_outputs),
    .renode_inputs  (renode_inputs),
    .rise_enable    (rise_enable),
    .fall_enable    (fall_enable),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver / scoreboard tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic [5:0] num, input logic val, input logic pulse,
                           input logic [15:0] cyc);
    bus_if.cmd_valid  = 1'b1;
    bus_if.cmd_number = num;
    bus_if.cmd_value  = val;
    bus_if.cmd_pulse  = pulse;
    bus_if.cmd_cycles = cyc;
  endtask

  // Called at a falling edge; waits (bounded) for an event, compares it with
  // the scoreboard head and consumes it with a one-edge evt_ready pulse.
  task automatic pop_event(input string tag);
    logic [5:0] exp;
    int waited;
    waited = 0;
    while (!bus_if.evt_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, bus_if.evt_valid, 1'b1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
    check({tag, "_numval"}, {bus_if.evt_number, bus_if.evt_value}, exp);
    bus_if.evt_ready = 1'b1;
    @(negedge clk);
    bus_if.evt_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rsp_seen;
    int out_bad;
    logic [31:0] exp_out;

    reset             = 1'b1;
    renode_inputs     = '0;
    rise_enable       = '1;
    fall_enable       = '1;
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_number = '0;
    bus_if.cmd_value  = 1'b0;
    bus_if.cmd_pulse  = 1'b0;
    bus_if.cmd_cycles = '0;
    bus_if.evt_ready  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus_if.cmd_ready, 1'b0);
    check("rst_outputs", renode_outputs, 32'h0);
    check("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
    check("rst_rsp_error", bus_if.rsp_error, 1'b0);
    check("rst_evt_valid", bus_if.evt_valid, 1'b0);
    check("rst_coalesced", bus_if.evt_coalesced, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus_if.cmd_ready, 1'b1);

    // Level command {3,1}: effect two edges after acceptance
    drive_cmd(6'd3, 1'b1, 1'b0, 16'd0);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    check("lvl_early_out", renode_outputs, 32'h0);
    check("lvl_early_rsp", bus_if.rsp_valid, 1'b0);
    @(negedge clk);
    check("lvl_out", renode_outputs, 32'h8);
    check("lvl_rsp_valid", bus_if.rsp_valid, 1'b1);
    check("lvl_rsp_error", bus_if.rsp_error, 1'b0);
    @(negedge clk);
    check("lvl_rsp_one_cycle", bus_if.rsp_valid, 1'b0);

    // Out-of-range index 40
    drive_cmd(6'd40, 1'b1, 1'b0, 16'd0);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    check("oor_early_rsp", bus_if.rsp_valid, 1'b0);
    @(negedge clk);
    check("oor_rsp_valid", bus_if.rsp_valid, 1'b1);
    check("oor_rsp_error", bus_if.rsp_error, 1'b1);
    check("oor_outputs", renode_outputs, 32'h8);
    @(negedge clk);

    // Pulse {0,1,5} at T followed by level {1,1} at T+1.
    // out[0] high for edges T+2..T+6, low at T+7; out[1] rises at T+8.
    drive_cmd(6'd0, 1'b1, 1'b1, 16'd5);
    @(negedge clk);
    check("pulse_ready2", bus_if.cmd_ready, 1'b1);
    drive_cmd(6'd1, 1'b1, 1'b0, 16'd0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 6) exp_out = 32'h9;
      else if (k >= 8)      exp_out = 32'hA;
      else                  exp_out = 32'h8;
      check($sformatf("pulse_out_k%0d", k), renode_outputs, exp_out);
      check($sformatf("pulse_rsp_k%0d", k), bus_if.rsp_valid, (k == 2 || k == 8));
      if (k == 1) bus_if.cmd_valid = 1'b0;
    end

    // Inputs 2 and 7 rise together: events (2,1) then (7,1)
    renode_inputs[2] = 1'b1;
    renode_inputs[7] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("edge_evt_early", bus_if.evt_valid, 1'b0);
    @(negedge clk);
    check("edge_evt_latency", bus_if.evt_valid, 1'b1);
    exp_q.push_back({5'd2, 1'b1});
    exp_q.push_back({5'd7, 1'b1});
    pop_event("edge_first");
    pop_event("edge_second");

    // Disabled fall edge on input 2 produces nothing
    fall_enable      = ~32'h4;
    renode_inputs[2] = 1'b0;
    repeat (6) @(negedge clk);
    check("fall_disabled_evt", bus_if.evt_valid, 1'b0);
    fall_enable = '1;
    repeat (2) @(negedge clk);
    check("fall_reenable_evt", bus_if.evt_valid, 1'b0);

    // Fill the event queue with input-5 toggles, then coalesce
    for (int t = 0; t < 8; t++) begin
      renode_inputs[5] = ~renode_inputs[5];
      exp_q.push_back({5'd5, renode_inputs[5]});
      repeat (3) @(negedge clk);
    end
    check("fill_coalesced0", bus_if.evt_coalesced, 1'b0);
    renode_inputs[5] = 1'b1;  // pending behind a full queue
    repeat (3) @(negedge clk);
    check("fill_pending_coalesced0", bus_if.evt_coalesced, 1'b0);
    check("hold_head_a", {bus_if.evt_number, bus_if.evt_value}, 6'h0B);
    renode_inputs[5] = 1'b0;  // edge on an already-pending input
    repeat (3) @(negedge clk);
    check("coalesced_set", bus_if.evt_coalesced, 1'b1);
    check("hold_head_b", {bus_if.evt_number, bus_if.evt_value}, 6'h0B);
    exp_q.push_back({5'd5, 1'b0});
    for (int e = 0; e < 9; e++) pop_event($sformatf("drain%0d", e));
    repeat (3) @(negedge clk);
    check("drain_empty", bus_if.evt_valid, 1'b0);
    check("drain_sb_empty", exp_q.size(), 0);
    check("coalesced_sticky", bus_if.evt_coalesced, 1'b1);

    // Reset during a 100-cycle pulse with three queued commands
    drive_cmd(6'd4, 1'b1, 1'b1, 16'd100);
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      drive_cmd(6'(c), 1'b1, 1'b0, 16'd0);
    end
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("long_pulse_out", renode_outputs, 32'h1A);
    check("long_pulse_state", dbg_state, 2'd2);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_outputs", renode_outputs, 32'h0);
    check("midrst_ready", bus_if.cmd_ready, 1'b0);
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_coalesced", bus_if.evt_coalesced, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("postrst_ready", bus_if.cmd_ready, 1'b1);
    rsp_seen = 0;
    out_bad  = 0;
    for (int w = 0; w < 120; w++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) rsp_seen++;
      if (renode_outputs != 32'h0) out_bad++;
    end
    check("postrst_no_rsp", rsp_seen, 0);
    check("postrst_outputs_zero", out_bad, 0);
    check("postrst_no_prime_evt", bus_if.evt_valid, 1'b0);
    check("postrst_state", dbg_state, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
